// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: powerdown, DRI divider writes,
// release and lock qualification with retry and loss-of-lock monitor.
module pll_reconfig_ctrl #(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned DRI_TIMEOUT  = 255,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [7:0]  ADDR_RFDIV   = 8'h08,
  parameter logic [7:0]  ADDR_FBINT   = 8'h0C,
  parameter logic [7:0]  ADDR_DIV0    = 8'h20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_req,
  input  logic [5:0]  cfg_rfdiv,
  input  logic [11:0] cfg_fbint,
  input  logic [6:0]  cfg_div0,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  cfg_err_code,
  output logic        lock_lost,
  output logic        pll_locked,
  output logic        pll_powerdown_n,
  input  logic        pll_lock,
  output logic        dri_sel,
  output logic        dri_wen,
  output logic [7:0]  dri_addr,
  output logic [31:0] dri_wdata,
  input  logic        dri_ready
);

  typedef enum logic [2:0] {
    IDLE, PWRDN, WR_RFDIV, WR_FBINT,
    WR_DIV0, RELEASE, WAIT_LOCK, FAIL
  } state_t;

  localparam logic [15:0] PD_LAST  = 16'(PD_CYCLES - 1);
  localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] LT_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] DRI_LAST = 16'(DRI_TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  state_t      state, state_n;
  logic [1:0]  sync;
  logic        lock_s;
  logic [15:0] cnt, cnt_n;
  logic [15:0] stable, stable_n;
  logic [2:0]  retry, retry_n;
  logic [5:0]  rfdiv_q, rfdiv_n;
  logic [11:0] fbint_q, fbint_n;
  logic [6:0]  div0_q, div0_n;
  logic        busy_n, done_n, err_n, lost_n;
  logic        locked_n, pdn_n, sel_n, wen_n;
  logic [1:0]  code_n;
  logic [7:0]  addr_n;
  logic [31:0] wdata_n;
  state_t      wr_next;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  assign lock_s = sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync            <= '0;
      state           <= IDLE;
      cnt             <= '0;
      stable          <= '0;
      retry           <= '0;
      rfdiv_q         <= '0;
      fbint_q         <= '0;
      div0_q          <= '0;
      cfg_busy        <= 1'b0;
      cfg_done        <= 1'b0;
      cfg_err         <= 1'b0;
      cfg_err_code    <= 2'd0;
      lock_lost       <= 1'b0;
      pll_locked      <= 1'b0;
      pll_powerdown_n <= 1'b1;
      dri_sel         <= 1'b0;
      dri_wen         <= 1'b0;
      dri_addr        <= '0;
      dri_wdata       <= '0;
    end else begin
      sync            <= {sync[0], pll_lock};
      state           <= state_n;
      cnt             <= cnt_n;
      stable          <= stable_n;
      retry           <= retry_n;
      rfdiv_q         <= rfdiv_n;
      fbint_q         <= fbint_n;
      div0_q          <= div0_n;
      cfg_busy        <= busy_n;
      cfg_done        <= done_n;
      cfg_err         <= err_n;
      cfg_err_code    <= code_n;
      lock_lost       <= lost_n;
      pll_locked      <= locked_n;
      pll_powerdown_n <= pdn_n;
      dri_sel         <= sel_n;
      dri_wen         <= wen_n;
      dri_addr        <= addr_n;
      dri_wdata       <= wdata_n;
    end
  end

  // Follow-on write for each DRI state; DIV0 hands over to RELEASE.
  always_comb begin
    wr_next = RELEASE;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      WR_RFDIV: begin
        wr_next = WR_FBINT;
        wr_addr = ADDR_FBINT;
        wr_data = {20'd0, fbint_q};
      end
      WR_FBINT: begin
        wr_next = WR_DIV0;
        wr_addr = ADDR_DIV0;
        wr_data = {25'd0, div0_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    stable_n = stable;
    retry_n  = retry;
    rfdiv_n  = rfdiv_q;
    fbint_n  = fbint_q;
    div0_n   = div0_q;
    busy_n   = cfg_busy;
    done_n   = 1'b0;
    lost_n   = 1'b0;
    err_n    = cfg_err;
    code_n   = cfg_err_code;
    locked_n = pll_locked;
    pdn_n    = pll_powerdown_n;
    sel_n    = dri_sel;
    wen_n    = dri_wen;
    addr_n   = dri_addr;
    wdata_n  = dri_wdata;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (cfg_req) begin
          rfdiv_n  = cfg_rfdiv;
          fbint_n  = cfg_fbint;
          div0_n   = cfg_div0;
          err_n    = 1'b0;
          code_n   = 2'd0;
          retry_n  = '0;
          locked_n = 1'b0;
          busy_n   = 1'b1;
          pdn_n    = 1'b0;
          state_n  = PWRDN;
        end else if (pll_locked && !lock_s) begin
          locked_n = 1'b0;
          lost_n   = 1'b1;
        end
      end
      PWRDN: begin
        if (cnt == PD_LAST) begin
          state_n = WR_RFDIV;
          cnt_n   = '0;
          addr_n  = ADDR_RFDIV;
          wdata_n = {26'd0, rfdiv_q};
        end
      end
      WR_RFDIV, WR_FBINT, WR_DIV0: begin
        // First cycle in each write state keeps the request low.
        if (!dri_sel) begin
          sel_n = 1'b1;
          wen_n = 1'b1;
          cnt_n = '0;
        end else if (dri_ready) begin
          sel_n   = 1'b0;
          wen_n   = 1'b0;
          cnt_n   = '0;
          state_n = wr_next;
          addr_n  = wr_addr;
          wdata_n = wr_data;
          if (wr_next == RELEASE) begin
            pdn_n    = 1'b1;
            stable_n = '0;
          end
        end else if (cnt == DRI_LAST) begin
          sel_n   = 1'b0;
          wen_n   = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
          cnt_n   = '0;
          err_n   = 1'b1;
          code_n  = 2'd1;
          busy_n  = 1'b0;
          pdn_n   = 1'b1;
          state_n = FAIL;
        end
      end
      RELEASE: begin
        cnt_n    = '0;
        stable_n = '0;
        state_n  = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)
          stable_n = (stable == 16'hFFFF) ? stable : stable + 16'd1;
        else
          stable_n = '0;
        if (lock_s && stable == STB_LAST) begin
          locked_n = 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          cnt_n    = '0;
          state_n  = IDLE;
        end else if (cnt == LT_LAST) begin
          cnt_n = '0;
          if (retry < RETRY_MAX) begin
            retry_n = retry + 3'd1;
            pdn_n   = 1'b0;
            state_n = PWRDN;
          end else begin
            err_n   = 1'b1;
            code_n  = 2'd2;
            busy_n  = 1'b0;
            pdn_n   = 1'b1;
            state_n = FAIL;
          end
        end
      end
      FAIL: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: nominal, glitch, retry,
// DRI timeout, loss of lock and mid-sequence reset.
module tb_pll_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_req;
  logic [5:0]  cfg_rfdiv;
  logic [11:0] cfg_fbint;
  logic [6:0]  cfg_div0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [1:0]  cfg_err_code;
  logic        lock_lost, pll_locked, pll_powerdown_n;
  logic        pll_lock;
  logic        dri_sel, dri_wen;
  logic [7:0]  dri_addr;
  logic [31:0] dri_wdata;
  logic        dri_ready;

  int n_cmp = 0;
  int n_err = 0;
  int nw = 0;
  int npd = 0;
  logic [7:0]  log_addr [64];
  logic [31:0] log_data [64];
  logic        pdn_prev = 1'b1;
  logic        bridge_on = 1'b1;
  int          rdy_cnt = 0;

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(400)) dut (
    .clk(clk), .resetn(resetn), .cfg_req(cfg_req),
    .cfg_rfdiv(cfg_rfdiv), .cfg_fbint(cfg_fbint), .cfg_div0(cfg_div0),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_err_code(cfg_err_code), .lock_lost(lock_lost),
    .pll_locked(pll_locked), .pll_powerdown_n(pll_powerdown_n),
    .pll_lock(pll_lock), .dri_sel(dri_sel), .dri_wen(dri_wen),
    .dri_addr(dri_addr), .dri_wdata(dri_wdata), .dri_ready(dri_ready)
  );

  always #5 clk = ~clk;

  // Bridge model: READY on the third cycle of a request.
  always @(negedge clk) begin
    if (bridge_on && dri_sel && !dri_ready) begin
      rdy_cnt = rdy_cnt + 1;
      if (rdy_cnt == 3) dri_ready = 1'b1;
    end else begin
      dri_ready = 1'b0;
      rdy_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (dri_sel && dri_wen && dri_ready && nw < 64) begin
      log_addr[nw] = dri_addr;
      log_data[nw] = dri_wdata;
      nw = nw + 1;
    end
    if (pdn_prev && !pll_powerdown_n) npd = npd + 1;
    pdn_prev = pll_powerdown_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [5:0] r, input logic [11:0] f,
                         input logic [6:0] d);
    cfg_rfdiv = r;
    cfg_fbint = f;
    cfg_div0  = d;
    cfg_req   = 1'b1;
    tick();
    cfg_req   = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 400 && nw < target; i++) tick();
  endtask

  task automatic chk_writes(input string tag, input int base,
                            input logic [31:0] r, input logic [31:0] f,
                            input logic [31:0] d);
    chk({tag, "_a0"}, 32'(log_addr[base]), 32'h08);
    chk({tag, "_d0"}, log_data[base], r);
    chk({tag, "_a1"}, 32'(log_addr[base+1]), 32'h0C);
    chk({tag, "_d1"}, log_data[base+1], f);
    chk({tag, "_a2"}, 32'(log_addr[base+2]), 32'h20);
    chk({tag, "_d2"}, log_data[base+2], d);
  endtask

  initial begin
    int base, pbase, c, early;
    logic seen;
    resetn = 1'b0;
    cfg_req = 1'b0;
    cfg_rfdiv = '0;
    cfg_fbint = '0;
    cfg_div0 = '0;
    pll_lock = 1'b0;
    dri_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_code", 32'(cfg_err_code), 0);
    chk("rst_locked", 32'(pll_locked), 0);
    chk("rst_pdn", 32'(pll_powerdown_n), 1);
    chk("rst_sel", 32'(dri_sel), 0);
    chk("rst_addr", 32'(dri_addr), 0);
    chk("rst_wdata", dri_wdata, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Nominal
    base = nw;
    request(6'd4, 12'd125, 7'd125);
    chk("nom_busy", 32'(cfg_busy), 1);
    chk("nom_pdn0", 32'(pll_powerdown_n), 0);
    wait_writes(base + 3);
    chk("nom_nw", 32'(nw - base), 3);
    chk("nom_pdn1", 32'(pll_powerdown_n), 1);
    chk_writes("nom", base, 4, 125, 125);
    repeat (100) tick();
    pll_lock = 1'b1;
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      c++;
      seen = cfg_done;
    end
    chk("nom_lat", 32'(c), 66);
    chk("nom_busy_f", 32'(cfg_busy), 0);
    chk("nom_locked", 32'(pll_locked), 1);
    chk("nom_err", 32'(cfg_err), 0);
    tick();
    chk("nom_done_1cy", 32'(cfg_done), 0);

    // Loss of lock while idle
    pll_lock = 1'b0;
    tick();
    chk("ll_p1", 32'(lock_lost), 0);
    tick();
    chk("ll_p2", 32'(lock_lost), 0);
    tick();
    chk("ll_p3", 32'(lock_lost), 1);
    chk("ll_locked", 32'(pll_locked), 0);
    tick();
    chk("ll_p4", 32'(lock_lost), 0);

    // Glitchy lock plus ignored request while busy
    base = nw;
    request(6'd5, 12'd100, 7'd7);
    repeat (3) tick();
    request(6'd9, 12'd200, 7'd50);
    chk("ign_busy", 32'(cfg_busy), 1);
    wait_writes(base + 3);
    chk("gl_nw", 32'(nw - base), 3);
    chk_writes("gl", base, 5, 100, 7);
    repeat (20) tick();
    pll_lock = 1'b1;
    early = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_done) early++;
    end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      c++;
      seen = cfg_done;
    end
    chk("gl_early", 32'(early), 0);
    chk("gl_lat", 32'(c), 66);
    chk("gl_locked", 32'(pll_locked), 1);

    // Lock never arrives: retries exhausted
    pll_lock = 1'b0;
    repeat (5) tick();
    base = nw;
    pbase = npd;
    request(6'd3, 12'd60, 7'd10);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      seen = cfg_err;
    end
    chk("rt_err", 32'(cfg_err), 1);
    chk("rt_code", 32'(cfg_err_code), 2);
    chk("rt_busy", 32'(cfg_busy), 0);
    chk("rt_pdn", 32'(pll_powerdown_n), 1);
    chk("rt_nw", 32'(nw - base), 12);
    chk("rt_npd", 32'(npd - pbase), 4);
    chk("rt_locked", 32'(pll_locked), 0);

    // DRI READY never returns
    repeat (3) tick();
    bridge_on = 1'b0;
    base = nw;
    pbase = npd;
    request(6'd4, 12'd125, 7'd125);
    chk("dt_err_clr", 32'(cfg_err), 0);
    c = 1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      c++;
      seen = cfg_err;
    end
    chk("dt_lat", 32'(c), 273);
    chk("dt_code", 32'(cfg_err_code), 1);
    chk("dt_sel", 32'(dri_sel), 0);
    chk("dt_busy", 32'(cfg_busy), 0);
    repeat (40) tick();
    chk("dt_npd", 32'(npd - pbase), 1);
    chk("dt_nw", 32'(nw - base), 0);
    chk("dt_idle_busy", 32'(cfg_busy), 0);

    // Reset during WR_FBINT, then a clean sequence
    bridge_on = 1'b1;
    base = nw;
    request(6'd1, 12'd2, 7'd3);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = dri_sel && (dri_addr == 8'h0C);
    end
    chk("rs_in_fb", 32'(seen), 1);
    resetn = 1'b0;
    #1;
    chk("rs_busy", 32'(cfg_busy), 0);
    chk("rs_pdn", 32'(pll_powerdown_n), 1);
    chk("rs_sel", 32'(dri_sel), 0);
    chk("rs_addr", 32'(dri_addr), 0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (10) tick();
    chk("rs_nw", 32'(nw - base), 1);
    base = nw;
    request(6'd6, 12'd80, 7'd20);
    wait_writes(base + 3);
    chk_writes("rs2", base, 6, 80, 20);
    repeat (5) tick();
    pll_lock = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = cfg_done;
    end
    chk("rs2_done", 32'(seen), 1);
    chk("rs2_locked", 32'(pll_locked), 1);
    chk("rs2_err", 32'(cfg_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
